conv11_bias_ctrl: RTL and testbench

Sequencer for the 1x1-conv bias path.
- On `start`, walks output channels 0..OUT_CH-1. For each channel it:
  - fetches the bias word from the bias ROM,
  - loads it into the bias buffer (load_en/load_data, waits for bias_load),
  - waits for the MAC engine's per-channel request, issues read_en, waits for the buffer's valid, then acks the engine.
- Sits between the bias ROM, the conv11 bias buffer and the conv11 accumulate stage.

---
 rtl/conv11_bias_ctrl.sv | 135 +++++++++++++
 tb/tb_conv11_bias_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv11_bias_ctrl.sv
// Bias-path sequencer for the 1x1 conv: per output channel it fetches the bias word from ROM,
// loads it into the bias buffer, then serves the MAC engine's request through a buffer read.
//
// state      | meaning
// IDLE       | waiting for start
// FETCH      | ROM read strobe for ch_idx
// CAPTURE    | ROM data lands in load_data
// LOAD       | buffer load strobe
// WAIT_LOAD  | waiting for buffer load-complete
// WAIT_REQ   | waiting for engine request
// READ       | buffer read strobe
// WAIT_VALID | waiting for buffer output-valid
// ACK        | ack engine; advance or finish
// DONE       | layer complete pulse
module conv11_bias_ctrl #(
    parameter int BIAS_WIDTH = 32,
    parameter int OUT_CH     = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BIAS_WIDTH-1:0] mem_rd_data,
    output logic                  load_en,
    output logic [BIAS_WIDTH-1:0] load_data,
    input  logic                  bias_load,
    input  logic                  ch_req,
    output logic                  read_en,
    input  logic                  bias_valid,
    output logic                  ch_ack,
    output logic [ADDR_WIDTH-1:0] ch_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_LOAD,
        S_WAIT_LOAD,
        S_WAIT_REQ,
        S_READ,
        S_WAIT_VALID,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(OUT_CH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   ch_idx_nxt;
    logic [BIAS_WIDTH-1:0]   load_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ch_idx    <= '0;
            load_data <= '0;
        end else begin
            state     <= state_nxt;
            ch_idx    <= ch_idx_nxt;
            load_data <= load_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ch_idx_nxt    = ch_idx;
        load_data_nxt = load_data;
        mem_rd_en     = 1'b0;
        load_en       = 1'b0;
        read_en       = 1'b0;
        ch_ack        = 1'b0;
        done          = 1'b0;

        // Moore outputs, decoded from the state register only.
        case (state)
            S_FETCH: mem_rd_en = 1'b1;
            S_LOAD:  load_en   = 1'b1;
            S_READ:  read_en   = 1'b1;
            S_ACK:   ch_ack    = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase

        // abort drops back to IDLE without capturing, so load_data keeps its last word.
        if (abort) begin
            state_nxt  = S_IDLE;
            ch_idx_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch_idx_nxt = '0;
                        state_nxt  = S_FETCH;
                    end
                end
                S_FETCH:   state_nxt = S_CAPTURE;
                S_CAPTURE: begin
                    load_data_nxt = mem_rd_data;
                    state_nxt     = S_LOAD;
                end
                S_LOAD:    state_nxt = S_WAIT_LOAD;
                S_WAIT_LOAD: begin
                    if (bias_load) state_nxt = S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (ch_req) state_nxt = S_READ;
                end
                S_READ:    state_nxt = S_WAIT_VALID;
                S_WAIT_VALID: begin
                    if (bias_valid) state_nxt = S_ACK;
                end
                S_ACK: begin
                    if (ch_idx == LAST_CH) begin
                        state_nxt = S_DONE;
                    end else begin
                        ch_idx_nxt = ch_idx + ADDR_WIDTH'(1);
                        state_nxt  = S_FETCH;
                    end
                end
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    assign mem_addr = ch_idx;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_conv11_bias_ctrl.sv
// Directed bench for conv11_bias_ctrl: ROM and bias-buffer responders with programmable
// delays, event recording per cycle, and hand-computed cycle/value expectations.
module tb_conv11_bias_ctrl;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, abort, bias_load, ch_req, bias_valid;
    logic [31:0] mem_rd_data;

    logic        a_rd_en, a_load_en, a_read_en, a_ack, a_busy, a_done;
    logic [3:0]  a_addr, a_idx;
    logic [31:0] a_ld;
    logic        b_rd_en, b_load_en, b_read_en, b_ack, b_busy, b_done;
    logic [3:0]  b_addr, b_idx;
    logic [31:0] b_ld;

    logic        sel;
    logic        m_rd_en, m_load_en, m_read_en, m_ack, m_busy, m_done;
    logic [3:0]  m_addr, m_idx;
    logic [31:0] m_ld;

    always #5 clk = ~clk;

    conv11_bias_ctrl #(.BIAS_WIDTH(32), .OUT_CH(4), .ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(mem_rd_data),
        .load_en(a_load_en), .load_data(a_ld), .bias_load(bias_load),
        .ch_req(ch_req), .read_en(a_read_en), .bias_valid(bias_valid),
        .ch_ack(a_ack), .ch_idx(a_idx), .busy(a_busy), .done(a_done)
    );

    conv11_bias_ctrl #(.BIAS_WIDTH(32), .OUT_CH(1), .ADDR_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(mem_rd_data),
        .load_en(b_load_en), .load_data(b_ld), .bias_load(bias_load),
        .ch_req(ch_req), .read_en(b_read_en), .bias_valid(bias_valid),
        .ch_ack(b_ack), .ch_idx(b_idx), .busy(b_busy), .done(b_done)
    );

    always_comb begin
        if (sel) begin
            m_rd_en = b_rd_en; m_load_en = b_load_en; m_read_en = b_read_en; m_ack = b_ack;
            m_busy = b_busy; m_done = b_done; m_addr = b_addr; m_idx = b_idx; m_ld = b_ld;
        end else begin
            m_rd_en = a_rd_en; m_load_en = a_load_en; m_read_en = a_read_en; m_ack = a_ack;
            m_busy = a_busy; m_done = a_done; m_addr = a_addr; m_idx = a_idx; m_ld = a_ld;
        end
    end

    logic [31:0] rom [4];

    int vectors = 0;
    int miscompares = 0;

    int load_dly, valid_dly, req_dly, abort_ch, rst_ch, restart_ch;
    int n_load, n_read, n_done, done_cyc;
    int ack_cyc[$];
    int ack_idx[$];
    int read_cyc[$];
    int rd_addr[$];
    logic [31:0] ld_vals[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int ld, input int vd, input int rd);
        load_dly = ld; valid_dly = vd; req_dly = rd;
        abort_ch = -1; rst_ch = -1; restart_ch = -1;
    endtask

    // Called at #1 after a rising edge with the selected DUT idle; start goes high for that cycle (cycle 0).
    task automatic run(input int budget);
        int pend, load_cnt, valid_cnt, req_cnt;
        logic prev_load;
        pend = -1; load_cnt = 0; valid_cnt = 0; req_cnt = 0; prev_load = 1'b0;
        n_load = 0; n_read = 0; n_done = 0; done_cyc = -1;
        ack_cyc.delete(); ack_idx.delete(); read_cyc.delete(); rd_addr.delete(); ld_vals.delete();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        bias_load = 1'b0; bias_valid = 1'b0; ch_req = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
            mem_rd_data = (pend >= 0) ? rom[pend] : 32'hDEAD_BEEF;
            pend = -1;
            if (m_rd_en) begin pend = int'(m_addr); rd_addr.push_back(int'(m_addr)); end
            if (m_load_en) begin n_load++; ld_vals.push_back(m_ld); end
            if (m_read_en) begin n_read++; read_cyc.push_back(cyc); end
            if (m_ack) begin ack_cyc.push_back(cyc); ack_idx.push_back(int'(m_idx)); end
            if (m_done) begin n_done++; done_cyc = cyc; end

            bias_load = 1'b0;
            if (load_cnt > 0) begin load_cnt--; bias_load = (load_cnt == 0); end
            if (m_load_en) load_cnt = load_dly + 1;
            bias_valid = 1'b0;
            if (valid_cnt > 0) begin valid_cnt--; bias_valid = (valid_cnt == 0); end
            if (m_read_en) valid_cnt = valid_dly + 1;
            ch_req = (req_cnt == 0);
            if (req_cnt > 0) req_cnt--;
            if (bias_load) req_cnt = req_dly;

            if (restart_ch >= 0 && m_rd_en && int'(m_idx) == restart_ch) start_a = 1'b1;
            if (abort_ch >= 0 && m_read_en && int'(m_idx) == abort_ch) abort = 1'b1;
            if (rst_ch >= 0 && prev_load && int'(m_idx) == rst_ch) rst = 1'b1;
            prev_load = m_load_en;
            if (abort || rst || m_done) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL timeout: no done/abort/rst within %0d cycles", budget);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom[0] = 32'h0000_0011; rom[1] = 32'h0000_0022; rom[2] = 32'hFFFF_FFF0; rom[3] = 32'h7FFF_FFFF;
        sel = 1'b0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        bias_load = 1'b0; bias_valid = 1'b0; ch_req = 1'b0; mem_rd_data = '0;
        set_cfg(0, 0, 0);
        tick(); tick();
        check("rst_busy", 32'(a_busy), 0);
        check("rst_ch_idx", 32'(a_idx), 0);
        check("rst_load_data", a_ld, 0);
        check("rst_strobes", {27'd0, a_rd_en, a_load_en, a_read_en, a_ack, a_done}, 0);
        rst = 1'b0;
        tick();

        // 1: nominal layer
        run(200);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_load_data%0d", i), (ld_vals.size() > i) ? ld_vals[i] : 32'hX, rom[i]);
            check($sformatf("t1_ack_cyc%0d", i), (ack_cyc.size() > i) ? 32'(ack_cyc[i]) : 32'hX, 32'(8 * (i + 1)));
            check($sformatf("t1_ack_idx%0d", i), (ack_idx.size() > i) ? 32'(ack_idx[i]) : 32'hX, 32'(i));
            check($sformatf("t1_mem_addr%0d", i), (rd_addr.size() > i) ? 32'(rd_addr[i]) : 32'hX, 32'(i));
        end
        check("t1_done_cyc", 32'(done_cyc), 33);
        tick();
        check("t1_busy_after", 32'(a_busy), 0);
        check("t1_idx_after_done", 32'(a_idx), 3);

        // 2: ch_req held off 5 cycles per channel
        set_cfg(0, 0, 5);
        run(300);
        check("t2_read_cyc0", (read_cyc.size() > 0) ? 32'(read_cyc[0]) : 32'hX, 11);
        check("t2_read_cyc3", (read_cyc.size() > 3) ? 32'(read_cyc[3]) : 32'hX, 50);
        check("t2_n_load", 32'(n_load), 4);
        check("t2_done_cyc", 32'(done_cyc), 53);
        tick();

        // 3: slow buffer responses
        set_cfg(3, 2, 0);
        run(300);
        check("t3_n_load", 32'(n_load), 4);
        check("t3_n_read", 32'(n_read), 4);
        check("t3_n_ack", 32'(ack_cyc.size()), 4);
        check("t3_ack_cyc0", (ack_cyc.size() > 0) ? 32'(ack_cyc[0]) : 32'hX, 13);
        check("t3_done_cyc", 32'(done_cyc), 53);
        tick();

        // 4: start while busy
        set_cfg(0, 0, 0);
        restart_ch = 1;
        run(200);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_ack_idx%0d", i), (ack_idx.size() > i) ? 32'(ack_idx[i]) : 32'hX, 32'(i));
        check("t4_done_cyc", 32'(done_cyc), 33);
        tick(); tick();
        check("t4_single_done", 32'(n_done), 1);
        check("t4_busy_after", 32'(a_busy), 0);

        // 5: abort in READ of channel 2, then restart
        set_cfg(0, 0, 0);
        abort_ch = 2;
        run(200);
        check("t5_abort_read_cyc", (read_cyc.size() > 2) ? 32'(read_cyc[2]) : 32'hX, 22);
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(a_busy), 0);
        check("t5_ch_idx", 32'(a_idx), 0);
        check("t5_done", 32'(a_done), 0);
        check("t5_load_data_kept", a_ld, rom[2]);
        check("t5_no_done", 32'(n_done), 0);
        set_cfg(0, 0, 0);
        run(200);
        check("t5_restart_addr", (rd_addr.size() > 0) ? 32'(rd_addr[0]) : 32'hX, 0);
        check("t5_restart_ack0", (ack_cyc.size() > 0) ? 32'(ack_cyc[0]) : 32'hX, 8);
        check("t5_restart_done", 32'(done_cyc), 33);
        tick();

        // 6a: rst during WAIT_LOAD of channel 1
        set_cfg(3, 0, 0);
        rst_ch = 1;
        run(200);
        check("t6_ack_before_rst", 32'(ack_cyc.size()), 1);
        tick();
        rst = 1'b0;
        check("t6_busy", 32'(a_busy), 0);
        check("t6_ch_idx", 32'(a_idx), 0);
        check("t6_load_data", a_ld, 0);
        check("t6_strobes", {27'd0, a_rd_en, a_load_en, a_read_en, a_ack, a_done}, 0);

        // 6b: single-channel instance
        sel = 1'b1;
        set_cfg(0, 0, 0);
        run(100);
        check("t6b_n_ack", 32'(ack_cyc.size()), 1);
        check("t6b_ack_cyc", (ack_cyc.size() > 0) ? 32'(ack_cyc[0]) : 32'hX, 8);
        check("t6b_load_data", (ld_vals.size() > 0) ? ld_vals[0] : 32'hX, rom[0]);
        check("t6b_done_cyc", 32'(done_cyc), 9);
        tick();
        check("t6b_busy_after", 32'(b_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
